// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and frame constants for the UART command path.
package uart_pkg;
  typedef enum logic [2:0] {
    IDLE, GET_CMD, GET_DATA, GET_CHK, EXEC, RD_WAIT, RESP
  } state_e;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int CMD_WRITE_BIT = 7;
endpackage

// File: rtl/uart_timeout_cnt.sv
// uart_timeout_cnt: idle-cycle counter with a terminal-count pulse at TIMEOUT_CYC.
module uart_timeout_cnt #(
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int CW = $clog2(TIMEOUT_CYC);
  logic [CW-1:0] cnt_q, cnt_d;
  // tc fires on the enabled cycle that would bring the count to TIMEOUT_CYC
  always_comb begin
    tc = en & ~clr & (cnt_q == CW'(TIMEOUT_CYC - 1));
    cnt_d = (clr | tc) ? '0 : en ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: turns SYNC/CMD/DATA/CHK byte frames into register accesses.
module uart_rx_frame_ctrl
  import uart_pkg::*;
#(
  parameter int          ADDR_W      = 4,
  parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter int          TIMEOUT_CYC = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_data_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_endofpacket,
  output logic              wr_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        wr_data,
  input  logic [7:0]        rd_data,
  output logic              rsp_valid,
  output logic [7:0]        rsp_data,
  input  logic              rsp_ready,
  output logic              busy,
  input  logic              err_clr,
  output logic [7:0]        err_cnt
);
  localparam logic [7:0] RSV_MASK = 8'((8'h7F >> ADDR_W) << ADDR_W);
  state_e state_q, state_d, byte_nxt;
  logic [7:0] cmd_q, cmd_d, data_q, data_d, chk_q, chk_d;
  logic [7:0] rsp_data_q, rsp_data_d, err_cnt_q, err_cnt_d;
  logic in_get, tmo, good, eop_abort, err_ev;
  assign in_get = state_q inside {GET_CMD, GET_DATA, GET_CHK};
  uart_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
    .clk(clk),
    .rst(rst),
    .clr(rx_data_ready | ~in_get),
    .en (in_get),
    .tc (tmo)
  );
  always_comb begin
    good = ((cmd_q ^ data_q) == chk_q) && ((cmd_q & RSV_MASK) == 8'h00);
    cmd_d = cmd_q;
    data_d = data_q;
    chk_d = chk_q;
    byte_nxt = state_q;
    case (state_q)
      IDLE:     if (rx_data_ready && rx_data == SYNC_BYTE) byte_nxt = GET_CMD;
      GET_CMD:  if (rx_data_ready) begin cmd_d = rx_data; byte_nxt = GET_DATA; end else if (tmo) byte_nxt = IDLE;
      GET_DATA: if (rx_data_ready) begin data_d = rx_data; byte_nxt = GET_CHK; end else if (tmo) byte_nxt = IDLE;
      GET_CHK:  if (rx_data_ready) begin chk_d = rx_data; byte_nxt = EXEC; end else if (tmo) byte_nxt = IDLE;
      EXEC:     byte_nxt = (good && !cmd_q[CMD_WRITE_BIT]) ? RD_WAIT : IDLE;
      RD_WAIT:  byte_nxt = RESP;
      RESP:     if (rsp_ready) byte_nxt = IDLE;
      default:  byte_nxt = IDLE;
    endcase
    // end-of-packet is judged against the state the byte (if any) moved us to
    eop_abort = rx_endofpacket && (byte_nxt inside {GET_CMD, GET_DATA, GET_CHK});
    state_d = eop_abort ? IDLE : byte_nxt;
    err_ev = eop_abort | tmo | (state_q == EXEC && !good) |
             (rx_data_ready && (state_q inside {EXEC, RD_WAIT, RESP}));
    err_cnt_d = err_clr ? 8'h00 : (err_ev && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    rsp_data_d = (state_q == RD_WAIT) ? rd_data : rsp_data_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      data_q     <= '0;
      chk_q      <= '0;
      rsp_data_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      data_q     <= data_d;
      chk_q      <= chk_d;
      rsp_data_q <= rsp_data_d;
      err_cnt_q  <= err_cnt_d;
    end
  end
  assign busy      = state_q != IDLE;
  assign wr_en     = state_q == EXEC && good && cmd_q[CMD_WRITE_BIT];
  assign rd_en     = state_q == EXEC && good && !cmd_q[CMD_WRITE_BIT];
  assign reg_addr  = cmd_q[ADDR_W-1:0];
  assign wr_data   = data_q;
  assign rsp_valid = state_q == RESP;
  assign rsp_data  = rsp_data_q;
  assign err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: directed and randomized frame checks against a frame-level model.
module tb_uart_rx_frame_ctrl;
  localparam int AW = 4;
  localparam logic [7:0] SYNC = 8'hA5;
  logic clk = 0, rst = 1;
  logic rx_data_ready = 0, rx_endofpacket = 0, rsp_ready = 0, err_clr = 0;
  logic [7:0] rx_data = 0, rd_data = 0;
  logic wr_en, rd_en, rsp_valid, busy;
  logic [AW-1:0] reg_addr;
  logic [7:0] wr_data, rsp_data, err_cnt;
  int total = 0, bad = 0, exp_err = 0, gapmax = 0;

  uart_rx_frame_ctrl #(.ADDR_W(AW), .SYNC_BYTE(SYNC), .TIMEOUT_CYC(100)) dut (
    .clk(clk), .rst(rst), .rx_data_ready(rx_data_ready), .rx_data(rx_data),
    .rx_endofpacket(rx_endofpacket), .wr_en(wr_en), .rd_en(rd_en), .reg_addr(reg_addr),
    .wr_data(wr_data), .rd_data(rd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_ready(rsp_ready), .busy(busy), .err_clr(err_clr), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(); @(negedge clk); endtask
  task automatic idle(input int n); repeat (n) @(negedge clk); endtask
  task automatic send(input logic [7:0] b);
    rx_data = b; rx_data_ready = 1; @(negedge clk); rx_data_ready = 0;
  endtask
  task automatic bump(); exp_err = (exp_err >= 255) ? 255 : exp_err + 1; endtask

  // frame is accepted when checksum matches and no address-reserved CMD bit is set
  function automatic bit model_ok(input logic [7:0] c, input logic [7:0] d, input logic [7:0] k);
    return (k == (c ^ d)) && (int'(c & 8'h7F) < (1 << AW));
  endfunction

  task automatic frame(input logic [7:0] c, input logic [7:0] d, input logic [7:0] k,
                       input logic [7:0] rv, input int hold, input int ovr);
    send(SYNC); idle($urandom_range(0, gapmax));
    send(c);    idle($urandom_range(0, gapmax));
    send(d);    idle($urandom_range(0, gapmax));
    chk("no_early_strobe", {wr_en, rd_en}, 0);
    send(k);
    if (!model_ok(c, d, k)) begin
      bump();
      chk("bad_no_strobe", {wr_en, rd_en}, 0);
      step();
      chk("bad_idle", busy, 0);
    end else if (c[7]) begin
      chk("wr_en", {wr_en, rd_en}, 2'b10);
      chk("wr_addr", reg_addr, c[AW-1:0]);
      chk("wr_data", wr_data, d);
      step();
      chk("wr_single", {wr_en, busy}, 0);
    end else begin
      chk("rd_en", {wr_en, rd_en}, 2'b01);
      chk("rd_addr", reg_addr, c[AW-1:0]);
      rd_data = ~rv;
      step();
      chk("rd_wait", {rd_en, rsp_valid}, 0);
      rd_data = rv;
      step();
      rd_data = ~rv;
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_data", rsp_data, rv);
      for (int i = 0; i < ovr; i++) begin
        send(8'h30 + 8'(i));
        bump();
      end
      repeat (hold) begin
        step();
        chk("rsp_hold", {rsp_valid, rsp_data}, {1'b1, rv});
      end
      rsp_ready = 1; step(); rsp_ready = 0;
      chk("rsp_done", {rsp_valid, busy}, 0);
    end
    chk("err_cnt", err_cnt, exp_err);
  endtask

  initial begin
    logic [7:0] c, d, k;
    idle(2); rst = 0; step();
    chk("rst_strobes", {busy, wr_en, rd_en, rsp_valid}, 0);
    chk("rst_vals", {reg_addr, wr_data, rsp_data, err_cnt}, 0);
    // good write, good read with backpressure, bad checksum, reserved bit
    frame(8'h83, 8'h5C, 8'hDF, 0, 0, 0);
    frame(8'h02, 8'h00, 8'h02, 8'h7E, 10, 0);
    frame(8'h83, 8'h5C, 8'h00, 0, 0, 0);
    frame(8'h93, 8'h00, 8'h93, 0, 0, 0);
    chk("err_two", err_cnt, 2);
    // timeout after CMD byte
    send(SYNC); send(8'h81); idle(99);
    chk("tmo_not_yet", busy, 1);
    step(); bump();
    chk("tmo_idle", busy, 0);
    chk("tmo_err", err_cnt, exp_err);
    // end-of-packet abort, then ignored in IDLE
    send(SYNC); rx_endofpacket = 1; step(); rx_endofpacket = 0; bump();
    chk("eop_abort", {busy, err_cnt}, {1'b0, 8'(exp_err)});
    rx_endofpacket = 1; step(); rx_endofpacket = 0;
    chk("eop_idle", {busy, err_cnt}, {1'b0, 8'(exp_err)});
    frame(8'h85, 8'h11, 8'h94, 0, 0, 0);
    // CHK byte and end-of-packet together: byte taken first
    send(SYNC); send(8'h81); send(8'h22);
    rx_data = 8'hA3; rx_data_ready = 1; rx_endofpacket = 1; step();
    rx_data_ready = 0; rx_endofpacket = 0;
    chk("byte_eop_wr", {wr_en, reg_addr, wr_data}, {1'b1, 4'h1, 8'h22});
    step();
    chk("byte_eop_err", err_cnt, exp_err);
    // overrun in RESP, then noise in IDLE
    frame(8'h05, 8'h99, 8'h9C, 8'h3C, 2, 3);
    send(8'h00); send(8'hFF);
    chk("noise", {busy, err_cnt}, {1'b0, 8'(exp_err)});
    // saturation
    repeat (260) begin
      send(SYNC); rx_endofpacket = 1; step(); rx_endofpacket = 0; bump();
    end
    chk("saturate", err_cnt, 255);
    send(SYNC); rx_endofpacket = 1; err_clr = 1; step();
    rx_endofpacket = 0; err_clr = 0; exp_err = 0;
    chk("clr_wins", err_cnt, 0);
    // reset mid-GET_DATA
    frame(8'h81, 8'h01, 8'h00, 0, 0, 0);
    send(SYNC); send(8'h83);
    rst = 1; step();
    chk("rst_mid", {busy, wr_en, rd_en, rsp_valid, reg_addr, wr_data, err_cnt}, 0);
    rst = 0; exp_err = 0;
    // reset while a response is pending
    send(SYNC); send(8'h02); send(8'h00); send(8'h02); rd_data = 8'h55; idle(2);
    chk("resp_pending", rsp_valid, 1);
    rst = 1; step(); rst = 0;
    chk("rst_resp", {rsp_valid, rsp_data, busy}, 0);
    // randomized frames with inter-byte gaps and idle noise
    gapmax = 3;
    for (int n = 0; n < 40; n++) begin
      k = 8'($urandom);
      if (k != SYNC) send(k);
      c = {1'($urandom), ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000, 4'($urandom)};
      d = 8'($urandom);
      k = ($urandom_range(0, 3) == 0) ? 8'($urandom) : c ^ d;
      frame(c, d, k, 8'($urandom), $urandom_range(0, 4), $urandom_range(0, 1));
    end
    chk("final_err", err_cnt, exp_err);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
Command-frame controller that sits behind the UART receiver (async_receiver byte interface) and turns a raw byte stream into register-bank accesses. It hunts for a sync byte, collects a 4-byte frame, checks it, then issues one write strobe or one read strobe. For reads it holds a response byte for the transmit path under a valid/ready handshake. Protocol errors are counted in a saturating counter.

Parameters:
ADDR_W, 4, register address width (1..7); CMD bits [6:ADDR_W] must be zero
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT_CYC, 65535, max clk cycles between bytes inside a frame (>=2)

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous, active-high reset
rx_data_ready  input  1  one-cycle strobe: rx_data valid
rx_data  input  8  received byte
rx_endofpacket  input  1  one-cycle strobe: line went idle
wr_en  output  1  one-cycle register write strobe
rd_en  output  1  one-cycle register read strobe
reg_addr  output  ADDR_W  address for wr_en/rd_en
wr_data  output  8  write data, valid with wr_en
rd_data  input  8  register read data, valid exactly 1 cycle after rd_en
rsp_valid  output  1  response byte available for transmitter
rsp_data  output  8  response byte, stable while rsp_valid
rsp_ready  input  1  transmitter accepts rsp_data when rsp_valid & rsp_ready
busy  output  1  high in every state except IDLE
err_clr  input  1  clears err_cnt
err_cnt  output  8  saturating protocol-error count

Behaviour:
- Reset: state IDLE; wr_en, rd_en, rsp_valid, busy = 0; reg_addr, wr_data, rsp_data, err_cnt = 0; timeout counter = 0.
- Frame: SYNC_BYTE, CMD, DATA, CHK. CMD[7]=1 write, 0 read; CMD[ADDR_W-1:0] address. CHK must equal CMD ^ DATA. DATA is sent but ignored for reads.
- States: IDLE -> (byte==SYNC_BYTE) GET_CMD -> (byte) GET_DATA -> (byte) GET_CHK -> (byte) EXEC. Non-sync bytes in IDLE are dropped silently, no error.
- EXEC (1 cycle): checks CHK and reserved CMD bits. Bad -> err event, IDLE. Good write -> wr_en=1 for this cycle with reg_addr/wr_data, then IDLE. Good read -> rd_en=1, then RD_WAIT.
- Latency: wr_en/rd_en assert the cycle after the CHK byte strobe.
- RD_WAIT (1 cycle): capture rd_data into rsp_data; rsp_valid=1 next cycle; go RESP.
- RESP: hold rsp_valid and rsp_data until a cycle with rsp_ready=1, then rsp_valid=0 and IDLE. rsp_ready while rsp_valid=0 is ignored.
- Bytes arriving in EXEC, RD_WAIT or RESP are dropped; each one is an err event (overrun).
- Timeout: the counter resets on entry to GET_CMD and on every rx_data_ready. It increments in GET_CMD/GET_DATA/GET_CHK. At TIMEOUT_CYC: err event, IDLE.
- rx_endofpacket in GET_CMD/GET_DATA/GET_CHK: err event, IDLE. Ignored in other states.
- Same-cycle rx_data_ready and timeout: the byte wins and the counter resets.
- Same-cycle rx_data_ready and rx_endofpacket: the byte is processed, then endofpacket is evaluated against the new state.
- err_cnt: +1 per err event, saturates at 255. err_clr forces 0 and wins over a same-cycle increment. At most one err event per cycle.
- busy is combinational from the state (state != IDLE).
- rst asserted mid-frame or in RESP: immediate return to reset values, pending response discarded.

Decomposition:
- Shared package uart_pkg: state enum (IDLE, GET_CMD, GET_DATA, GET_CHK, EXEC, RD_WAIT, RESP), SYNC_BYTE default, CMD_WRITE_BIT index = 7.
- One sub-module: uart_timeout_cnt (clear, enable, terminal-count pulse at TIMEOUT_CYC), reused later for the TX path.
- err_cnt saturation logic stays inline.

Test Plan:
- Good write: bytes A5,83,5C,DF (CHK=83^5C=DF) -> single wr_en cycle one clk after the DF strobe, reg_addr=3, wr_data=5C; err_cnt=0.
- Good read with backpressure: A5,02,00,02; rd_data=7E one cycle after rd_en; rsp_ready low 10 cycles -> rsp_valid held with rsp_data=7E; rsp_ready high 1 cycle -> rsp_valid drops, state IDLE.
- Bad checksum / reserved bits: A5,83,5C,00 -> no strobes, err_cnt=1; then A5,93,00,93 with ADDR_W=4 -> no strobes, err_cnt=2.
- Timeout and endofpacket abort: TIMEOUT_CYC=100; A5,81 then 100 idle cycles -> IDLE, err_cnt+1. A5 then rx_endofpacket -> IDLE, err_cnt+1. Following good frame executes normally.
- Overrun plus noise: send a read, then 3 bytes while in RESP -> err_cnt+3 and rsp_data unchanged. Bytes 00,FF in IDLE -> no error.
- Saturation/clear: force 260 err events -> err_cnt=255. err_clr coincident with an err event -> err_cnt=0. rst mid-GET_DATA -> all outputs at reset values next cycle.
